load_receiver: RTL
==================

// Module: load_receiver
// PURPOSE
//  Processor-side end of the serial load link. Deserialises 13-bit frames arriving on mosi_in
//  under mode_in, writes each frame into instruction or data memory, then starts the core and
//  reports completion back to the loader. Sits between the loader's serial pins and the core's
//  imem/dmem write ports and start/done pins.
// PARAMETERS
//  ADDR_W  4  memory address width; frame bits [ADDR_W-1:0] carry the address
//  DATA_W  8  memory word width; frame bits [ADDR_W+DATA_W-1:ADDR_W] carry the data
//  OVS     2  clocks per serial bit; sample history depth = OVS*(ADDR_W+DATA_W) = 24
// PORTS
//  clk           in   1       system clock; all logic on posedge
//  rst_n         in   1       asynchronous, active-low reset
//  mosi_in       in   1       serial data, LSB first, each bit held OVS clocks
//  mode_in       in   2       00 idle/frame end, 01 imem frame, 10 dmem frame, 11 run
//  core_done_in  in   1       core finished execution (level)
//  imem_we_o     out  1       one-cycle imem write strobe
//  dmem_we_o     out  1       one-cycle dmem write strobe
//  wr_addr_o     out  ADDR_W  write address, shared by both ports, valid with a strobe
//  wr_data_o     out  DATA_W  write data, valid with a strobe
//  core_start_o  out  1       one-cycle pulse on entry to run
//  core_run_o    out  1       high while in RUN
//  done_out      out  1       completion, returned to the loader's done_in
//  err_o         out  1       sticky protocol error
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; history and counters cleared. Asynchronous assertion;
//   synchronous release.
//  FSM: IDLE, RX_I, RX_D, RUN, HOLD.
//   IDLE: 01->RX_I; 10->RX_D; 11->RUN with core_start_o=1 for that one transition cycle.
//   RX_I/RX_D: each cycle, shift mosi_in into a 24-bit history register (sr[0] = newest) and
//    increment a saturating active-cycle counter. When mode_in==00, the frame ends -> IDLE.
//   RUN: core_run_o=1. When core_done_in=1 -> HOLD.
//   HOLD: done_out=1 and core_run_o=0. When mode_in==00 -> IDLE, with done_out low the next cycle.
//  Frame decode, on the cycle mode_in==00 is seen in RX_*:
//   bit k (k=0..11) = sr[OVS*(12-k)-1]. Frame bit 12 is pad; it is not sampled.
//  Write commit:
//   Registered; the strobe, wr_addr_o and wr_data_o are valid exactly 1 cycle after frame end.
//   imem_we_o is used for frames received in RX_I; dmem_we_o for frames received in RX_D.
//  Short frame: if the active-cycle count is < OVS*12 at frame end, the frame is discarded
//   (no strobe) and err_o is set.
//  Illegal mode change: any direct change between nonzero modes (01<->10, 01/10->11, 11->01/10)
//   discards any partial frame, sets err_o and goes to HOLD. HOLD then waits for 00.
//  err_o clears only on reset. The history register clears on entry to RX_*.
//  core_done_in already high on RUN entry: the block still spends 1 cycle in RUN (start pulse
//   issued), then moves to HOLD.
//  mode_in returning to 00 while in RUN (abort): -> IDLE, core_run_o drops, done_out stays 0.
//  Back-to-back frames: a single 00 cycle between frames is sufficient. The strobe for frame N
//   may coincide with the first RX cycle of frame N+1.
// STRUCTURE
//  Shared package tp_pkg:
//   mode_t enum (MODE_IDLE=2'b00, MODE_IMEM=2'b01, MODE_DMEM=2'b10, MODE_RUN=2'b11)
//   rx_state_t enum
//   FRAME_BITS = ADDR_W+DATA_W+1
//  Sub-module frame_sampler: history shift register, active-cycle counter, and bit-pick decode.
//   Outputs {addr, data, short_frame}.
// TESTING
//  1 mode 01 for 2 lead cycles; frame addr=5, data=0xA3, bit0 held 3 cycles, others 2; then 00
//    -> imem_we_o=1 for 1 cycle, 1 cycle after the 00 edge, wr_addr_o=5, wr_data_o=0xA3,
//       dmem_we_o=0.
//  2 16 dmem frames addr=i, data=0x10+i, one 00 cycle between frames
//    -> 16 dmem_we_o pulses with matching addr/data; err_o=0.
//  3 mode 01 for 10 cycles, then 00
//    -> no strobe; err_o=1 and stays 1 through later valid frames.
//  4 mode 11; core_done_in high 7 cycles later
//    -> core_start_o for 1 cycle; core_run_o for 7 cycles; done_out=1 one cycle after done;
//       mode 00 -> done_out=0 on the next cycle.
//  5 mode 01 for 8 cycles, then 10 with no 00 between
//    -> no strobe, err_o=1, state HOLD until 00.
//  6 rst_n low mid-frame (cycle 12 of 24), release, full frame addr=0xF, data=0xFF
//    -> outputs 0 during reset; the following frame writes 0xF/0xFF correctly.

Source files
------------

// File: rtl/tp_pkg.sv
// Shared types and constants for the serial load link receiver.
// Frame layout: address in the low bits, data above it, one trailing pad bit.
package tp_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int OVS_DEF    = 2;
  localparam int FRAME_BITS = ADDR_W_DEF + DATA_W_DEF + 1;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_IMEM = 2'b01,
    MODE_DMEM = 2'b10,
    MODE_RUN  = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_I,
    ST_RX_D,
    ST_RUN,
    ST_HOLD
  } rx_state_t;

endpackage

// File: rtl/frame_sampler.sv
// Oversampled history shift register plus active-cycle counter; picks one sample
// per serial bit out of the history to rebuild {data, addr}.
module frame_sampler
  import tp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int OVS    = OVS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_shift,
  input  logic              i_mosi,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_short
);

  localparam int NB    = ADDR_W + DATA_W;
  localparam int HIST  = OVS * NB;
  localparam int CNT_W = $clog2(HIST + 1);

  logic [HIST-1:0]  r_sr;
  logic [CNT_W-1:0] r_cnt;
  logic [NB-1:0]    w_frame;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_shift) begin
      r_sr <= {r_sr[HIST-2:0], i_mosi};
      if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Bit k was sent OVS*(NB-k) samples ago; take the oldest sample of each bit cell.
  always_comb begin
    w_frame = '0;
    for (int k = 0; k < NB; k++) w_frame[k] = r_sr[OVS*(NB-k)-1];
  end

  assign o_addr  = w_frame[ADDR_W-1:0];
  assign o_data  = w_frame[NB-1:ADDR_W];
  assign o_short = (r_cnt < CNT_W'(HIST));

endmodule

// File: rtl/load_receiver.sv
// Processor-side end of the serial load link: receives frames into imem/dmem,
// then starts the core and reports completion back to the loader.
module load_receiver
  import tp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int OVS    = OVS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mosi_in,
  input  logic [1:0]        mode_in,
  input  logic              core_done_in,
  output logic              imem_we_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              core_start_o,
  output logic              core_run_o,
  output logic              done_out,
  output logic              err_o
);

  logic              r_rst_meta, r_rst_sync;
  logic              w_rst_n;
  rx_state_t         r_state, w_state_nxt;
  mode_t             w_mode;
  logic              w_clr, w_shift, w_frame_end, w_err_set, w_start;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_short;
  logic              r_imem_we_p1, r_dmem_we_p1, r_err;
  logic [ADDR_W-1:0] r_wr_addr_p1;
  logic [DATA_W-1:0] r_wr_data_p1;

  // Reset asserts immediately but releases two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end
  assign w_rst_n = r_rst_sync;

  assign w_mode = mode_t'(mode_in);

  frame_sampler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OVS(OVS)) u_sampler (
    .clk     (clk),
    .rst_n   (w_rst_n),
    .i_clr   (w_clr),
    .i_shift (w_shift),
    .i_mosi  (mosi_in),
    .o_addr  (w_addr),
    .o_data  (w_data),
    .o_short (w_short)
  );

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_shift     = 1'b0;
    w_frame_end = 1'b0;
    w_err_set   = 1'b0;
    w_start     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        unique case (w_mode)
          MODE_IMEM: begin w_state_nxt = ST_RX_I; w_clr = 1'b1; end
          MODE_DMEM: begin w_state_nxt = ST_RX_D; w_clr = 1'b1; end
          MODE_RUN:  begin w_state_nxt = ST_RUN;  w_start = 1'b1; end
          default:   ;
        endcase
      end
      ST_RX_I, ST_RX_D: begin
        if (w_mode == MODE_IDLE) begin
          w_state_nxt = ST_IDLE;
          w_frame_end = 1'b1;
        end else if ((r_state == ST_RX_I && w_mode == MODE_IMEM) ||
                     (r_state == ST_RX_D && w_mode == MODE_DMEM)) begin
          w_shift = 1'b1;
        end else begin
          w_state_nxt = ST_HOLD;
          w_err_set   = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_mode == MODE_IDLE) begin
          w_state_nxt = ST_IDLE;
        end else if (w_mode != MODE_RUN) begin
          w_state_nxt = ST_HOLD;
          w_err_set   = 1'b1;
        end else if (core_done_in) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_mode == MODE_IDLE) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Commit stage: strobe, address and data land one cycle after the frame end.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_imem_we_p1 <= 1'b0;
      r_dmem_we_p1 <= 1'b0;
      r_wr_addr_p1 <= '0;
      r_wr_data_p1 <= '0;
      r_err        <= 1'b0;
    end else begin
      r_imem_we_p1 <= w_frame_end && !w_short && (r_state == ST_RX_I);
      r_dmem_we_p1 <= w_frame_end && !w_short && (r_state == ST_RX_D);
      if (w_frame_end && !w_short) begin
        r_wr_addr_p1 <= w_addr;
        r_wr_data_p1 <= w_data;
      end
      r_err <= r_err | w_err_set | (w_frame_end & w_short);
    end
  end

  assign imem_we_o    = r_imem_we_p1;
  assign dmem_we_o    = r_dmem_we_p1;
  assign wr_addr_o    = r_wr_addr_p1;
  assign wr_data_o    = r_wr_data_p1;
  assign err_o        = r_err;
  assign core_start_o = w_start;
  assign core_run_o   = (r_state == ST_RUN);
  assign done_out     = (r_state == ST_HOLD);

endmodule
